// File: rtl/mult_68n_core.sv
// Pipelined unsigned multiplier, WIDTH x WIDTH -> WIDTH (low word of product).
// Two register stages: partial products, then the summed result.
// Any non-zero high word of the full product raises overflow.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   dataa/datab carry a valid operand pair this cycle
//   dataa      multiplicand, unsigned
//   datab      multiplier, unsigned
//   out_valid  result/overflow carry a new product this cycle
//   result     low WIDTH bits of dataa*datab
//   overflow   high WIDTH bits of the full product are non-zero
module mult_68n_core #(
  parameter int unsigned WIDTH = 32  // must be even
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int unsigned H = WIDTH / 2;

  // Operand halves
  logic [H-1:0] al, ah, bl, bh;
  assign al = dataa[H-1:0];
  assign ah = dataa[WIDTH-1:H];
  assign bl = datab[H-1:0];
  assign bh = datab[WIDTH-1:H];

  // Stage 1: partial products
  logic [WIDTH-1:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
  logic [WIDTH-1:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic             v1_q;

  always_comb begin
    pp_ll_d = {{H{1'b0}}, al} * {{H{1'b0}}, bl};
    pp_lh_d = {{H{1'b0}}, al} * {{H{1'b0}}, bh};
    pp_hl_d = {{H{1'b0}}, ah} * {{H{1'b0}}, bl};
    pp_hh_d = {{H{1'b0}}, ah} * {{H{1'b0}}, bh};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      pp_hh_q <= '0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= in_valid;
      // Hold partial products across bubbles
      if (in_valid) begin
        pp_ll_q <= pp_ll_d;
        pp_lh_q <= pp_lh_d;
        pp_hl_q <= pp_hl_d;
        pp_hh_q <= pp_hh_d;
      end
    end
  end

  // Stage 2: recombine into the full 2*WIDTH product
  logic [WIDTH:0]       mid_sum;   // keeps the carry of the middle sum
  logic [2*WIDTH-1:0]   full;
  logic [WIDTH-1:0]     result_d, result_q;
  logic                 overflow_d, overflow_q;
  logic                 out_valid_q;

  always_comb begin
    mid_sum    = {1'b0, pp_lh_q} + {1'b0, pp_hl_q};
    full       = {{WIDTH{1'b0}}, pp_ll_q}
               + ({{(WIDTH-1){1'b0}}, mid_sum} << H)
               + {pp_hh_q, {WIDTH{1'b0}}};
    result_d   = full[WIDTH-1:0];
    overflow_d = |full[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        result_q   <= result_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mult_68n_core.sv
module tb_mult_68n_core;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] dataa;
  logic [W-1:0] datab;
  logic         out_valid;
  logic [W-1:0] result;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of full products for accepted pairs, in order.
  logic [2*W-1:0] exp_q[$];
  logic           prev_v;
  logic [W-1:0]   exp_res;
  logic           exp_ov;

  mult_68n_core #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .dataa    (dataa),
    .datab    (datab),
    .out_valid(out_valid),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present inputs, clock, then compare against the model.
  // Output after this edge reflects the pair presented on the previous step.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    in_valid = v;
    dataa    = a;
    datab    = b;
    @(posedge clk);
    #1;
    if (prev_v) begin
      if (exp_q.size() == 0) begin
        check("model_underflow", 64'd1, 64'd0);
      end else begin
        full    = exp_q.pop_front();
        exp_res = full[W-1:0];
        exp_ov  = (full[2*W-1:W] != '0);
      end
    end
    check("out_valid", {63'd0, out_valid}, {63'd0, prev_v});
    check("result",    {32'd0, result},    {32'd0, exp_res});
    check("overflow",  {63'd0, overflow},  {63'd0, exp_ov});
    if (v) exp_q.push_back({32'd0, a} * {32'd0, b});
    prev_v = v;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dataa    = '0;
    datab    = '0;
    prev_v   = 1'b0;
    exp_res  = '0;
    exp_ov   = 1'b0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result",    {32'd0, result},    64'd0);
    check("rst_overflow",  {63'd0, overflow},  64'd0);
    rst_n = 1'b1;

    // Single pair, then drain
    step(1'b1, 32'd1, 32'd2);
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);
    check("vec_1x2", {32'd0, result}, 64'd2);

    // Three back-to-back pairs
    step(1'b1, 32'd1,   32'd2);
    step(1'b1, 32'd332, 32'd22);
    step(1'b1, 32'd2,   32'd23);
    step(1'b0, 32'd0,   32'd0);
    step(1'b0, 32'd0,   32'd0);
    check("vec_last_46", {32'd0, result}, 64'd46);

    // Overflow boundaries
    step(1'b1, 32'h0001_0000, 32'h0001_0000);
    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(1'b1, 32'h0000_FFFF, 32'h0001_0001);
    step(1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
    step(1'b1, 32'h1234_5678, 32'h0000_0000);
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);
    check("vec_zero_ov", {63'd0, overflow}, 64'd0);

    // Bubble pattern 1,0,1 with changing data during the bubble
    step(1'b1, 32'd7,          32'd9);
    step(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    step(1'b1, 32'd5,          32'd11);
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb;
      logic         rv;
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom_range(0, 65535); rb = $urandom_range(0, 65535); end
        2: begin ra = $urandom; rb = 32'(($urandom_range(0, 1) != 0) ? 0 : 1); end
        default: begin ra = 32'hFFFF_0000 | $urandom_range(0, 65535); rb = $urandom; end
      endcase
      step(rv, ra, rb);
    end
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);

    // Asynchronous reset with a pair in flight
    step(1'b1, 32'd1000, 32'd1000);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_result",    {32'd0, result},    64'd0);
    check("arst_overflow",  {63'd0, overflow},  64'd0);
    exp_q.delete();
    prev_v  = 1'b0;
    exp_res = '0;
    exp_ov  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);

    // Normal operation resumes after reset
    step(1'b1, 32'd332, 32'd22);
    step(1'b0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);
    check("post_rst_7304", {32'd0, result}, 64'd7304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
